// File: rtl/step_clock_gen.sv
// Single-step pushbutton front end: sync, debounce, one fixed-width step_clk pulse per press.
// Optional auto-stepping divider and `run` input enabled by defining STEP_CLOCK_AUTO_RUN_EN.
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 16,
`ifdef STEP_CLOCK_AUTO_RUN_EN
  parameter int AUTO_DIV        = 25000000,
`endif
  parameter int CNT_W           = 20
) (
  input  logic        clk50M,
  input  logic        rst_n,
  input  logic        btn_raw,
`ifdef STEP_CLOCK_AUTO_RUN_EN
  input  logic        run,
`endif
  output logic        step_clk,
  output logic        step_busy,
  output logic        btn_level,
  output logic [15:0] step_count
);

  localparam int PC_W = $clog2(PULSE_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HIGH    = 2'd1;
  localparam logic [1:0] S_LOW     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             lvl_q, lvl_d, lvl_d1_q;
  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pcnt_q, pcnt_d;
  logic [15:0]      step_count_q, step_count_d;
  logic             step_clk_q, step_busy_q;
  logic             press, auto_inj, press_any;

  // Debounce: any sample matching the current level restarts the count.
  always_comb begin
    db_cnt_d = '0;
    lvl_d    = lvl_q;
    if (s2_q != lvl_q) begin
      if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) lvl_d = s2_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign press = lvl_q & ~lvl_d1_q;

`ifdef STEP_CLOCK_AUTO_RUN_EN
  localparam int DIV_W = $clog2(AUTO_DIV);

  logic             run_s1_q, run_s2_q;
  logic [DIV_W-1:0] div_q, div_d;

  // Divider only advances while idle, so the step period is AUTO_DIV plus the pulse/lockout time.
  always_comb begin
    div_d    = '0;
    auto_inj = 1'b0;
    if (run_s2_q) begin
      if (state_q == S_IDLE) begin
        if (div_q == DIV_W'(AUTO_DIV - 1)) auto_inj = 1'b1;
        else div_d = div_q + 1'b1;
      end else begin
        div_d = div_q;
      end
    end
  end

  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      div_q    <= '0;
    end else begin
      run_s1_q <= run;
      run_s2_q <= run_s1_q;
      div_q    <= div_d;
    end
  end
`else
  assign auto_inj = 1'b0;
`endif

  assign press_any = press | auto_inj;

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    step_count_d = step_count_q;
    case (state_q)
      S_IDLE: begin
        if (press_any) begin
          state_d      = S_HIGH;
          pcnt_d       = '0;
          step_count_d = step_count_q + 16'd1;
        end
      end
      S_HIGH: begin
        if (pcnt_q == PC_W'(PULSE_CYCLES - 1)) begin
          state_d = S_LOW;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_LOW: begin
        if (pcnt_q == PC_W'(PULSE_CYCLES - 1)) begin
          state_d = S_RELEASE;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!lvl_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next state so step_clk comes straight off a flop.
  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      db_cnt_q     <= '0;
      lvl_q        <= 1'b0;
      lvl_d1_q     <= 1'b0;
      state_q      <= S_IDLE;
      pcnt_q       <= '0;
      step_count_q <= '0;
      step_clk_q   <= 1'b0;
      step_busy_q  <= 1'b0;
    end else begin
      s1_q         <= btn_raw;
      s2_q         <= s1_q;
      db_cnt_q     <= db_cnt_d;
      lvl_q        <= lvl_d;
      lvl_d1_q     <= lvl_q;
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      step_count_q <= step_count_d;
      step_clk_q   <= (state_d == S_HIGH);
      step_busy_q  <= (state_d != S_IDLE);
    end
  end

  assign step_clk   = step_clk_q;
  assign step_busy  = step_busy_q;
  assign btn_level  = lvl_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen: cycle-accurate behavioural model checked every cycle, plus directed literal checks.
module tb_step_clock_gen;
  localparam int D  = 8;
  localparam int P  = 4;
  localparam int AD = 20;

  logic        clk50M = 1'b0;
  logic        rst_n, btn_raw, run;
  logic        step_clk, step_busy, btn_level;
  logic [15:0] step_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b1;

  always #5 clk50M = ~clk50M;

  step_clock_gen #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P),
`ifdef STEP_CLOCK_AUTO_RUN_EN
    .AUTO_DIV       (AD),
`endif
    .CNT_W          (4)
  ) dut (
    .clk50M    (clk50M),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
`ifdef STEP_CLOCK_AUTO_RUN_EN
    .run       (run),
`endif
    .step_clk  (step_clk),
    .step_busy (step_busy),
    .btn_level (btn_level),
    .step_count(step_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw -> 2-sample delay -> run-length debounce -> age since press.
  // age 0 = idle, 1..P = high, P+1..2P = guaranteed low, 2P+1 = waiting for release.
  logic        m_s1 = 0, m_s2 = 0, m_lvl = 0, m_lvl1 = 0;
  int          m_run = 0, m_age = 0;
  logic [15:0] m_cnt = 0;
  logic        m_r1 = 0, m_r2 = 0;
  int          m_div = 0;

  always @(posedge clk50M) begin
    logic o_s2, o_lvl, o_lvl1, o_r2, btn_press, inj;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl1 = 0; m_run = 0; m_age = 0; m_cnt = 0;
      m_r1 = 0; m_r2 = 0; m_div = 0;
    end else begin
      o_s2 = m_s2; o_lvl = m_lvl; o_lvl1 = m_lvl1; o_r2 = m_r2;
      btn_press = o_lvl && !o_lvl1;
      m_s2 = m_s1; m_s1 = btn_raw;
      m_r2 = m_r1; m_r1 = run;
      if (o_s2 != o_lvl) begin
        m_run++;
        if (m_run == D) begin m_lvl = o_s2; m_run = 0; end
      end else m_run = 0;
      m_lvl1 = o_lvl;
      inj = 1'b0;
`ifdef STEP_CLOCK_AUTO_RUN_EN
      if (!o_r2) m_div = 0;
      else if (m_age == 0) begin
        if (m_div == AD - 1) begin inj = 1'b1; m_div = 0; end
        else m_div++;
      end
`endif
      if (m_age == 0) begin
        if (btn_press || inj) begin m_age = 1; m_cnt = m_cnt + 16'd1; end
      end else if (m_age >= 2*P + 1) begin
        if (!o_lvl) m_age = 0;
      end else m_age++;
    end
  end

  always @(negedge clk50M) begin
    if (chk_en) begin
      chk("m_step_clk", {31'b0, step_clk}, {31'b0, (m_age >= 1 && m_age <= P)});
      chk("m_step_busy", {31'b0, step_busy}, {31'b0, (m_age != 0)});
      chk("m_btn_level", {31'b0, btn_level}, {31'b0, m_lvl});
      chk("m_step_count", {16'b0, step_count}, {16'b0, m_cnt});
    end
  end

  task automatic measure(input int n, output int hi, output int rises);
    logic prev;
    prev = step_clk; hi = 0; rises = 0;
    repeat (n) begin
      @(negedge clk50M);
      if (step_clk) hi++;
      if (step_clk && !prev) rises++;
      prev = step_clk;
    end
  endtask

  task automatic wait_high(input int budget, input string name);
    int k;
    k = 0;
    while (!step_clk && k < budget) begin @(negedge clk50M); k++; end
    chk(name, {31'b0, step_clk}, 32'd1);
  endtask

  initial begin
    int hi, r;
    rst_n = 0; btn_raw = 1; run = 0;
    // 1: reset, then a held button gives one pulse
    repeat (3) @(negedge clk50M);
    chk("t1_rst_step_clk", {31'b0, step_clk}, 32'd0);
    chk("t1_rst_count", {16'b0, step_count}, 32'd0);
    chk("t1_rst_busy", {31'b0, step_busy}, 32'd0);
    chk("t1_rst_level", {31'b0, btn_level}, 32'd0);
    rst_n = 1;
    repeat (9) @(negedge clk50M);
    chk("t1_level_early", {31'b0, btn_level}, 32'd0);
    @(negedge clk50M);
    chk("t1_level_rise", {31'b0, btn_level}, 32'd1);
    measure(20, hi, r);
    chk("t1_width", hi, 32'd4);
    chk("t1_rises", r, 32'd1);
    chk("t1_count", {16'b0, step_count}, 32'd1);
    btn_raw = 0;
    repeat (20) @(negedge clk50M);
    chk("t1_idle", {31'b0, step_busy}, 32'd0);

    // 2: short burst rejected, then a clean press
    btn_raw = 1; repeat (5) @(negedge clk50M);
    btn_raw = 0; repeat (3) @(negedge clk50M);
    btn_raw = 1; repeat (10) @(negedge clk50M);
    chk("t2_no_early", {31'b0, step_clk}, 32'd0);
    @(negedge clk50M);
    chk("t2_rise_at_11", {31'b0, step_clk}, 32'd1);
    @(negedge clk50M);
    btn_raw = 0;
    measure(25, hi, r);
    chk("t2_rest_width", hi, 32'd2);
    chk("t2_no_retrigger", r, 32'd0);
    chk("t2_count", {16'b0, step_count}, 32'd2);
    chk("t2_idle", {31'b0, step_busy}, 32'd0);

    // 3: long hold, single pulse, busy until debounced release
    btn_raw = 1;
    measure(200, hi, r);
    chk("t3_rises", r, 32'd1);
    chk("t3_width", hi, 32'd4);
    chk("t3_busy_held", {31'b0, step_busy}, 32'd1);
    btn_raw = 0;
    repeat (10) @(negedge clk50M);
    chk("t3_busy_until_fall", {31'b0, step_busy}, 32'd1);
    @(negedge clk50M);
    chk("t3_busy_clear", {31'b0, step_busy}, 32'd0);
    chk("t3_count", {16'b0, step_count}, 32'd3);

    // 4: wrap from 0xFFFF
    chk_en = 0;
    @(negedge clk50M);
    force dut.step_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk50M);
    release dut.step_count_q;
    @(negedge clk50M);
    chk_en = 1;
    chk("t4_preload", {16'b0, step_count}, 32'h0000FFFF);
    btn_raw = 1; repeat (20) @(negedge clk50M);
    btn_raw = 0; repeat (25) @(negedge clk50M);
    chk("t4_wrap", {16'b0, step_count}, 32'd0);

    // 5: reset during second high cycle, then a full pulse
    btn_raw = 1;
    wait_high(30, "t5_rise_timeout");
    @(negedge clk50M);
    chk("t5_second_high", {31'b0, step_clk}, 32'd1);
    rst_n = 0;
    @(negedge clk50M);
    chk("t5_rst_clk", {31'b0, step_clk}, 32'd0);
    chk("t5_rst_count", {16'b0, step_count}, 32'd0);
    chk("t5_rst_busy", {31'b0, step_busy}, 32'd0);
    rst_n = 1;
    measure(30, hi, r);
    chk("t5_full_width", hi, 32'd4);
    chk("t5_rises", r, 32'd1);
    chk("t5_count", {16'b0, step_count}, 32'd1);
    btn_raw = 0;
    repeat (25) @(negedge clk50M);

`ifdef STEP_CLOCK_AUTO_RUN_EN
    // 6: auto-run period and stop
    run = 1;
    wait_high(60, "t6_first_timeout");
    begin
      int k;
      k = 0;
      @(negedge clk50M); k++;
      while (step_clk && k < 60) begin @(negedge clk50M); k++; end
      while (!step_clk && k < 60) begin @(negedge clk50M); k++; end
      chk("t6_period", k, 32'd29);
    end
    run = 0;
    measure(100, hi, r);
    chk("t6_stop", r, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end
endmodule

// File: doc/step_clock_gen.md
Name: step_clock_gen

Overview:
- Board-level front end that turns the raw single-step pushbutton into the clean clock edge that advances the pipelined CPU.
- Sits directly upstream of the top-level stepped `clk` input.
- Runs on the 50 MHz board clock. Synchronises and debounces the button, then emits exactly one fixed-width high pulse per press.
- Keeps a 16-bit step counter for display on the SSD.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a new button level (20 ms at 50 MHz); minimum 2.
- PULSE_CYCLES, 16, board-clock cycles `step_clk` is held high, and again held low afterwards; minimum 1.
- CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.
- AUTO_DIV, 25000000, board cycles between automatic steps (Optional Feature only); minimum 2*PULSE_CYCLES+1.

Ports:
- clk50M  input  1  50 MHz board clock; only clock in the block.
- rst_n  input  1  reset, synchronous, active-low, sampled on rising clk50M.
- btn_raw  input  1  raw asynchronous pushbutton, active-high.
- step_clk  output  1  registered stepped clock to the pipeline.
- step_busy  output  1  high while a step pulse or its lockout is in progress.
- btn_level  output  1  debounced button level.
- step_count  output  16  number of steps issued; wraps.

Behaviour:
- Reset (rst_n low at a rising edge): next cycle all of the following are 0:
  - outputs step_clk, step_busy, btn_level, step_count;
  - internal sync flops, debounce counter, pulse counter;
  - FSM goes to IDLE.
- Reset mid-pulse truncates the pulse; no partial count is kept.
- Synchroniser: two flops on btn_raw. Their output is `sync`, 2 cycles latency.
- Debounce:
  - If sync == btn_level, the counter clears to 0.
  - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1 while still differing, btn_level <= sync and the counter clears.
  - Any glitch back to the old level restarts the count.
- Press event: a 0->1 transition of btn_level, seen as `press` for one cycle.
- FSM states:
  - IDLE: step_clk=0, step_busy=0. On press go to HIGH, step_count <= step_count+1, pulse counter <= 0.
  - HIGH: step_clk=1 for exactly PULSE_CYCLES cycles, then go to LOW.
  - LOW: step_clk=0 for PULSE_CYCLES cycles (guaranteed low time), then go to RELEASE.
  - RELEASE: wait for btn_level==0, then go to IDLE. Holding the button never re-triggers.
- step_busy=1 in HIGH, LOW and RELEASE.
- step_clk is driven straight from a flop (no combinational glitches). It rises 1 cycle after the press cycle.
- Total latency from a clean btn_raw rise to step_clk rise: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- A press arriving while busy is ignored; only IDLE samples press.
- step_count wraps from 0xFFFF to 0x0000 with no flag.
- A release followed by a re-press within the same cycle cannot occur, because btn_level changes at most once per DEBOUNCE_CYCLES.

Optional Feature:
- Macro: STEP_CLOCK_AUTO_RUN_EN.
- When defined:
  - An extra input `run` (1 bit, also passed through the 2-flop synchroniser) is added.
  - While synced run==1 and the FSM is in IDLE, a free-running divider counts to AUTO_DIV-1 and then injects a press; the divider clears on each injection.
  - The divider clears whenever run==0 or on reset.
  - Button presses still work; a button press and an auto press in the same cycle produce one step.
- When undefined: no `run` port, no divider. Behaviour is exactly as described above.

Test Plan (DEBOUNCE_CYCLES=8, PULSE_CYCLES=4, AUTO_DIV=20):
1. Hold rst_n=0 for 3 cycles with btn_raw=1, then release reset and keep btn_raw=1 → step_clk=0 and step_count=0 during reset. After reset, btn_level rises 10 cycles later and step_clk=1 for exactly 4 cycles. step_count=1.
2. btn_raw 1 for 5 cycles, 0 for 3, then 1 for 12 cycles → first burst rejected. Exactly one pulse of 4 high cycles, starting 11 cycles after the final rise. step_count +1.
3. Hold btn_raw=1 for 200 cycles → one pulse only; step_busy stays 1 until btn_level falls after release.
4. Preload 65535 presses (or force step_count=0xFFFF), then press once → step_count=0x0000.
5. Assert rst_n=0 during the 2nd high cycle of step_clk → step_clk=0, step_count=0, step_busy=0 on the next edge. The next press gives a full 4-cycle pulse.
6. (STEP_CLOCK_AUTO_RUN_EN) run=1, button idle → step_clk pulses every 20+9 cycles (divider plus pulse/lockout). run=0 → no further pulses after the current one completes.
